// File: rtl/seven_seg_pkg.sv
// Shared constants, pending-FSM state type and hex-to-segment decode for the
// eight-digit seven-segment display driver.
package seven_seg_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam logic [6:0]  SEG_BLANK  = 7'h7F;

    typedef enum logic {
        IDLE,
        PEND
    } pend_state_t;

    // Active-low {g,f,e,d,c,b,a} for a common-anode digit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_ctrl_scan.sv
// Refresh counter and digit index for the multiplexed display scan.
module digit_scan_timer #(
    parameter int unsigned REFRESH_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] index,
    output logic       tc,
    output logic       frame_boundary
);

    localparam int unsigned CW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;

    logic [CW-1:0] count_q;

    assign tc             = (count_q == CW'(REFRESH_CYCLES - 1));
    assign frame_boundary = tc && (index == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            index   <= 3'd0;
        end else if (tc) begin
            count_q <= '0;
            index   <= index + 3'd1;
        end else begin
            count_q <= count_q + CW'(1);
        end
    end

endmodule

// File: rtl/seven_seg_ctrl.sv
// Eight-digit hex display driver with tear-free frame-boundary updates and
// optional leading-zero blanking.
module seven_seg_ctrl
    import seven_seg_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        load,
    input  logic        blank_lz,
    input  logic [7:0]  dp_in,
    input  logic        en,
    output logic [7:0]  anode,
    output logic [6:0]  segment,
    output logic        dp,
    output logic        update_ack
);

    logic [2:0]  index;
    logic        tc;
    logic        frame_boundary;

    pend_state_t state_q;
    logic [31:0] pend_q;
    logic [31:0] disp_q;
    logic        ack_q;

    digit_scan_timer #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_scan (
        .clk           (clk),
        .rst           (rst),
        .index         (index),
        .tc            (tc),
        .frame_boundary(frame_boundary)
    );

    // A load on the boundary cycle wins over any older pending value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            disp_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load && frame_boundary) begin
                        disp_q <= data_in;
                        ack_q  <= 1'b1;
                    end else if (load) begin
                        pend_q  <= data_in;
                        state_q <= PEND;
                    end
                end
                PEND: begin
                    if (frame_boundary) begin
                        disp_q  <= load ? data_in : pend_q;
                        ack_q   <= 1'b1;
                        state_q <= IDLE;
                    end else if (load) begin
                        pend_q <= data_in;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign update_ack = ack_q;

    logic [NUM_DIGITS-1:0] lz_mask;
    logic [3:0]            nibble;
    logic                  blank;
    logic [7:0]            anode_d;
    logic [6:0]            segment_d;
    logic                  dp_d;

    // lz_mask[i] set when nibbles i..7 are all zero; digit 0 is never blanked.
    always_comb begin
        lz_mask = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            lz_mask[i] = ((disp_q >> (4 * i)) == 32'd0);
        end
    end

    always_comb begin
        nibble    = disp_q[{index, 2'b00} +: 4];
        blank     = !en || (blank_lz && lz_mask[index]);
        anode_d   = blank ? 8'hFF : ~(8'd1 << index);
        segment_d = blank ? SEG_BLANK : hex_to_seg(nibble);
        dp_d      = blank ? 1'b1 : ~dp_in[index];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anode   <= 8'hFF;
            segment <= SEG_BLANK;
            dp      <= 1'b1;
        end else begin
            anode   <= anode_d;
            segment <= segment_d;
            dp      <= dp_d;
        end
    end

endmodule

// File: tb/tb_seven_seg_ctrl.sv
// Randomized bench for seven_seg_ctrl against a cycle-count based display model.
module tb_seven_seg_ctrl;

    localparam int unsigned R = 4;
    localparam int unsigned FRAME = 8 * R;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        load;
    logic        blank_lz;
    logic [7:0]  dp_in;
    logic        en;
    logic [7:0]  anode;
    logic [6:0]  segment;
    logic        dp;
    logic        update_ack;

    always #5 clk = ~clk;

    seven_seg_ctrl #(
        .REFRESH_CYCLES(R)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .load      (load),
        .blank_lz  (blank_lz),
        .dp_in     (dp_in),
        .en        (en),
        .anode     (anode),
        .segment   (segment),
        .dp        (dp),
        .update_ack(update_ack)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model: time since reset release, displayed value, latest pending value.
    int unsigned m_time;
    logic [31:0] m_disp;
    logic [31:0] m_pend;
    bit          m_pv;
    logic [7:0]  e_anode;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_ack;

    function automatic bit next_is_boundary();
        return (m_time % FRAME) == FRAME - 1;
    endfunction

    task automatic model_reset();
        m_time = 0;
        m_disp = '0;
        m_pend = '0;
        m_pv   = 1'b0;
    endtask

    task automatic model_step();
        int unsigned d;
        int unsigned nib;
        bit          fb;
        bit          blanked;
        d       = (m_time / R) % 8;
        fb      = next_is_boundary();
        nib     = (m_disp >> (4 * d)) & 32'hF;
        blanked = !en || (blank_lz && d >= 1 && (m_disp >> (4 * d)) == 32'd0);
        e_anode = blanked ? 8'hFF : ~(8'h01 << d);
        e_seg   = blanked ? 7'h7F : seg_tab[nib];
        e_dp    = blanked ? 1'b1 : !dp_in[d];
        e_ack   = fb && (load || m_pv);
        if (fb && load) begin
            m_disp = data_in;
            m_pv   = 1'b0;
        end else if (fb && m_pv) begin
            m_disp = m_pend;
            m_pv   = 1'b0;
        end else if (load) begin
            m_pend = data_in;
            m_pv   = 1'b1;
        end
        m_time++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_anode"}, 32'(anode), 32'hFF);
        check_eq({tag, "_seg"}, 32'(segment), 32'h7F);
        check_eq({tag, "_dp"}, 32'(dp), 32'h1);
        check_eq({tag, "_ack"}, 32'(update_ack), 32'h0);
    endtask

    task automatic randomize_inputs();
        logic [3:0] rep;
        load = ($urandom_range(0, 15) == 0) || (next_is_boundary() && $urandom_range(0, 1) == 1);
        rep  = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 3))
            0:       data_in = $urandom;
            1:       data_in = $urandom >> (4 * $urandom_range(1, 7));
            2:       data_in = 32'd0;
            default: data_in = {8{rep}};
        endcase
        blank_lz = 1'($urandom_range(0, 1));
        en       = ($urandom_range(0, 7) != 0);
        dp_in    = 8'($urandom);
    endtask

    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            randomize_inputs();
            model_step();
            @(posedge clk);
            #1;
            check_eq("anode", 32'(anode), 32'(e_anode));
            check_eq("segment", 32'(segment), 32'(e_seg));
            check_eq("dp", 32'(dp), 32'(e_dp));
            check_eq("update_ack", 32'(update_ack), 32'(e_ack));
        end
        load = 1'b0;
    endtask

    // Assert reset between edges, check it acts without a clock, release after an edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs(tag);
        @(posedge clk);
        #1;
        check_reset_outputs({tag, "_held"});
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst      = 1'b1;
        data_in  = '0;
        load     = 1'b0;
        blank_lz = 1'b0;
        dp_in    = '0;
        en       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b0;
        model_reset();

        run_cycles(1500);

        // Reset mid-frame while digit 3 is being scanned.
        while ((m_time / R) % 8 != 3) run_cycles(1);
        run_cycles(1);
        async_reset("rst_digit3");

        run_cycles(1500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout total=%0d", total);
        $fatal(1, "timeout");
    end

endmodule
